// File: rtl/battle_if.sv
// Bus between the battle engine and the game-state controller / test harness.
interface battle_if;
   logic [7:0]      keycode;
   logic            is_battle;
   logic [2:0][2:0] my_team;
   logic [2:0]      cur_battle;
   logic [1:0]      my_cur;
   logic [2:0]      enemy_cur_id;
   logic            end_battle;
   logic            result;
   logic [5:0]      my_hp;
   logic [5:0]      enemy_hp;
   logic            player_turn;

   // Driver side: game state and keyboard
   modport master (
      output keycode, is_battle, my_team, cur_battle,
      input  my_cur, enemy_cur_id, end_battle, result, my_hp, enemy_hp, player_turn
   );

   // Battle engine side
   modport slave (
      input  keycode, is_battle, my_team, cur_battle,
      output my_cur, enemy_cur_id, end_battle, result, my_hp, enemy_hp, player_turn
   );
endinterface

// File: rtl/battle_engine.sv
// Turn-based battle controller: player/enemy turns, HP bookkeeping, win/loss report.
module battle_engine #(
   parameter logic [5:0]  FULL_HP     = 6'd32,
   parameter logic [24:0] ENEMY_DELAY = 25'd25000000
) (
   input logic     Clk,
   input logic     Reset,
   battle_if.slave bus
);
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_S     = 8'h16;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_PTURN, S_PRES, S_EWAIT, S_EATK, S_ERES, S_DONE, S_FINISH
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      prev_key;
   logic [2:0][5:0] hp, hp_nxt;
   logic [1:0]      cur, cur_nxt;
   logic [5:0]      ehp, ehp_nxt;
   logic [2:0]      eid, eid_nxt;
   logic            res, res_nxt;
   logic [24:0]     cnt, cnt_nxt;
   logic [5:0]      my_hp_q;
   logic            end_q, pturn_q;

   logic            key_evt, atk_evt, sw_evt, aborting;
   logic            alt_ok;
   logic [1:0]      alt_slot, s1, s2;
   logic [3:0]      p_atk, e_atk;

   function automatic logic [5:0] sat_sub(input logic [5:0] a, input logic [3:0] b);
      return (a > 6'(b)) ? a - 6'(b) : 6'd0;
   endfunction

   function automatic logic [1:0] next_slot(input logic [1:0] c);
      return (c == 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   // Key edge detection and attack powers
   always_comb begin
      key_evt  = (bus.keycode != 8'h00) && (bus.keycode != prev_key);
      atk_evt  = key_evt && (bus.keycode == KEY_ENTER);
      sw_evt   = key_evt && (bus.keycode == KEY_S);
      p_atk    = 4'(bus.my_team[cur]) + 4'd4;
      e_atk    = 4'(bus.cur_battle) + 4'd3;
      aborting = !bus.is_battle && (state inside {S_LOAD, S_PTURN, S_PRES, S_EWAIT, S_EATK, S_ERES});
   end

   // First alive slot after the active one, in rotation order
   always_comb begin
      s1       = next_slot(cur);
      s2       = next_slot(s1);
      alt_ok   = 1'b0;
      alt_slot = cur;
      if (hp[s1] != 6'd0) begin
         alt_ok   = 1'b1;
         alt_slot = s1;
      end else if (hp[s2] != 6'd0) begin
         alt_ok   = 1'b1;
         alt_slot = s2;
      end
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a dropped is_battle mid-battle returns to idle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.is_battle) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = S_PTURN;
         S_PTURN:  if (atk_evt)                state_nxt = S_PRES;
                   else if (sw_evt && alt_ok)  state_nxt = S_EWAIT;
         S_PRES:   state_nxt = (ehp == 6'd0) ? S_DONE : S_EWAIT;
         S_EWAIT:  if (cnt == ENEMY_DELAY - 25'd1) state_nxt = S_EATK;
         S_EATK:   state_nxt = S_ERES;
         S_ERES:   state_nxt = ((hp[cur] != 6'd0) || alt_ok) ? S_PTURN : S_DONE;
         S_DONE:   state_nxt = S_FINISH;
         S_FINISH: if (!bus.is_battle) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (aborting) state_nxt = S_IDLE;
   end

   // Datapath next values; an abort leaves every value untouched
   always_comb begin
      hp_nxt  = hp;
      cur_nxt = cur;
      ehp_nxt = ehp;
      eid_nxt = eid;
      res_nxt = res;
      cnt_nxt = cnt;
      if (!aborting) begin
         case (state)
            S_LOAD: begin
               hp_nxt  = {3{FULL_HP}};
               cur_nxt = 2'd0;
               ehp_nxt = 6'd24 + {1'b0, bus.cur_battle, 2'b00};
               eid_nxt = bus.cur_battle + 3'd4;
            end
            S_PTURN: begin
               if (atk_evt) begin
                  ehp_nxt = sat_sub(ehp, p_atk);
               end else if (sw_evt && alt_ok) begin
                  cur_nxt = alt_slot;
                  cnt_nxt = 25'd0;
               end
            end
            S_PRES: begin
               if (ehp == 6'd0) res_nxt = 1'b1;
               else             cnt_nxt = 25'd0;
            end
            S_EWAIT: cnt_nxt = cnt + 25'd1;
            S_EATK:  hp_nxt[cur] = sat_sub(hp[cur], e_atk);
            S_ERES: begin
               if (hp[cur] == 6'd0) begin
                  if (alt_ok) cur_nxt = alt_slot;
                  else        res_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         prev_key <= 8'h00;
         hp       <= '0;
         cur      <= 2'd0;
         ehp      <= 6'd0;
         eid      <= 3'd0;
         res      <= 1'b0;
         cnt      <= 25'd0;
         my_hp_q  <= 6'd0;
         end_q    <= 1'b0;
         pturn_q  <= 1'b0;
      end else begin
         prev_key <= bus.keycode;
         hp       <= hp_nxt;
         cur      <= cur_nxt;
         ehp      <= ehp_nxt;
         eid      <= eid_nxt;
         res      <= res_nxt;
         cnt      <= cnt_nxt;
         my_hp_q  <= hp_nxt[cur_nxt];
         end_q    <= (state_nxt == S_DONE);
         pturn_q  <= (state_nxt == S_PTURN);
      end
   end

   assign bus.my_cur       = cur;
   assign bus.enemy_cur_id = eid;
   assign bus.end_battle   = end_q;
   assign bus.result       = res;
   assign bus.my_hp        = my_hp_q;
   assign bus.enemy_hp     = ehp;
   assign bus.player_turn  = pturn_q;
endmodule

// File: tb/tb_battle_engine.sv
// Self-checking bench for battle_engine: vector table, directed sequences, random battles.
module tb_battle_engine;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_S     = 8'h16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   battle_if bus ();

   battle_engine #(.FULL_HP(6'd32), .ENEMY_DELAY(25'd4)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_end = 0;
   int   end_base = 0;
   logic end_res = 1'b0;

   typedef struct {
      logic [2:0] cb;
      logic [2:0] t0;
      int         ehp0;
      int         eid;
      int         ehp1;
   } vec_t;

   vec_t vt[6];

   // Count end_battle pulses and capture the result seen with each
   always @(posedge clk) begin
      if (bus.end_battle) begin
         n_end   <= n_end + 1;
         end_res <= bus.result;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic press(input logic [7:0] k, input int hold);
      bus.keycode = k;
      repeat (hold) tick();
      bus.keycode = 8'h00;
      tick();
   endtask

   task automatic wait_turn();
      int n = 0;
      while (!bus.player_turn && n < 200) begin
         tick();
         n++;
      end
      if (!bus.player_turn) chk("turn_timeout", 0, 1);
   endtask

   task automatic start(input logic [2:0] cb, input logic [2:0][2:0] tm);
      bus.cur_battle = cb;
      bus.my_team    = tm;
      bus.is_battle  = 1'b1;
      end_base       = n_end;
      tick();
      tick();
   endtask

   task automatic wait_end(input int exp);
      int n = 0;
      while (n_end == end_base && n < 200) begin
         tick();
         n++;
      end
      chk("end_count", n_end - end_base, 1);
      chk("end_result", int'(end_res), exp);
      chk("result_held", int'(bus.result), exp);
      chk("end_width", int'(bus.end_battle), 0);
      bus.is_battle = 1'b0;
      tick();
      tick();
      chk("idle_after_end", int'(bus.player_turn), 0);
   endtask

   task automatic abort_chk(input int ehp, input int mhp);
      bus.is_battle = 1'b0;
      tick();
      chk("abort_turn", int'(bus.player_turn), 0);
      repeat (3) tick();
      chk("abort_no_end", n_end - end_base, 0);
      chk("abort_ehp", int'(bus.enemy_hp), ehp);
      chk("abort_mhp", int'(bus.my_hp), mhp);
   endtask

   function automatic int find_alt(input int hp[3], input int c);
      for (int d = 1; d <= 2; d++)
         if (hp[(c + d) % 3] > 0) return (c + d) % 3;
      return -1;
   endfunction

   // One randomized battle against the arithmetic reference model
   task automatic rand_battle();
      logic [2:0]      cb;
      logic [2:0][2:0] tm;
      int php[3];
      int cur, ehp, alt, k, cbi, atk;
      bit over;
      cb  = 3'($urandom_range(0, 7));
      tm  = 9'($urandom);
      cbi = int'(cb);
      start(cb, tm);
      php  = '{32, 32, 32};
      cur  = 0;
      ehp  = 24 + 4 * cbi;
      over = 1'b0;
      chk("rnd_load_ehp", int'(bus.enemy_hp), ehp);
      chk("rnd_load_id", int'(bus.enemy_cur_id), (cbi + 4) % 8);
      for (int step = 0; step < 60 && !over; step++) begin
         if ($urandom_range(0, 3) == 0) begin
            k = int'($urandom_range(1, 255));
            if (k == 8'h28 || k == 8'h16) k = 8'h04;
            press(8'(k), int'($urandom_range(1, 3)));
            chk("rnd_junk_turn", int'(bus.player_turn), 1);
            chk("rnd_junk_ehp", int'(bus.enemy_hp), ehp);
         end
         if ($urandom_range(0, 3) == 0) begin
            alt = find_alt(php, cur);
            press(KEY_S, int'($urandom_range(1, 3)));
            if (alt < 0) begin
               chk("rnd_sw_stay", int'(bus.player_turn), 1);
               chk("rnd_sw_cur", int'(bus.my_cur), cur);
               continue;
            end
            cur = alt;
         end else begin
            atk = 4 + int'(tm[cur]);
            press(KEY_ENTER, int'($urandom_range(1, 3)));
            ehp = (ehp > atk) ? ehp - atk : 0;
            if (ehp == 0) begin
               wait_end(1);
               over = 1'b1;
               continue;
            end
         end
         php[cur] = (php[cur] > 3 + cbi) ? php[cur] - (3 + cbi) : 0;
         if (php[cur] == 0) begin
            alt = find_alt(php, cur);
            if (alt < 0) begin
               wait_end(0);
               over = 1'b1;
               continue;
            end
            cur = alt;
         end
         wait_turn();
         chk("rnd_cur", int'(bus.my_cur), cur);
         chk("rnd_my_hp", int'(bus.my_hp), php[cur]);
         chk("rnd_ehp", int'(bus.enemy_hp), ehp);
      end
      if (!over) abort_chk(ehp, php[cur]);
   endtask

   // Main sequence
   initial begin
      vt[0] = '{3'd0, 3'd7, 24, 4, 13};
      vt[1] = '{3'd7, 3'd0, 52, 3, 48};
      vt[2] = '{3'd3, 3'd5, 36, 7, 27};
      vt[3] = '{3'd5, 3'd2, 44, 1, 38};
      vt[4] = '{3'd1, 3'd0, 28, 5, 24};
      vt[5] = '{3'd6, 3'd4, 48, 2, 40};

      rst            = 1'b1;
      bus.keycode    = 8'h00;
      bus.is_battle  = 1'b0;
      bus.my_team    = '0;
      bus.cur_battle = 3'd0;
      tick();
      tick();
      chk("rst_my_cur", int'(bus.my_cur), 0);
      chk("rst_enemy_id", int'(bus.enemy_cur_id), 0);
      chk("rst_end", int'(bus.end_battle), 0);
      chk("rst_result", int'(bus.result), 0);
      chk("rst_my_hp", int'(bus.my_hp), 0);
      chk("rst_enemy_hp", int'(bus.enemy_hp), 0);
      chk("rst_turn", int'(bus.player_turn), 0);
      rst = 1'b0;
      tick();

      // Battle start values and first attack, then abort during the enemy wait
      for (int i = 0; i < 6; i++) begin
         start(vt[i].cb, {3'd0, 3'd0, vt[i].t0});
         chk("load_ehp", int'(bus.enemy_hp), vt[i].ehp0);
         chk("load_eid", int'(bus.enemy_cur_id), vt[i].eid);
         chk("load_my_hp", int'(bus.my_hp), 32);
         chk("load_turn", int'(bus.player_turn), 1);
         chk("load_cur", int'(bus.my_cur), 0);
         bus.keycode = KEY_ENTER;
         tick();
         chk("enter_ehp", int'(bus.enemy_hp), vt[i].ehp1);
         bus.keycode = 8'h00;
         tick();
         tick();
         abort_chk(vt[i].ehp1, 32);
      end

      // Win: three attacks of power 11 against 24 HP
      start(3'd0, {3'd2, 3'd1, 3'd7});
      press(KEY_ENTER, 2);
      wait_turn();
      chk("win_ehp1", int'(bus.enemy_hp), 13);
      chk("win_my_hp1", int'(bus.my_hp), 29);
      press(KEY_ENTER, 1);
      wait_turn();
      chk("win_ehp2", int'(bus.enemy_hp), 2);
      chk("win_my_hp2", int'(bus.my_hp), 26);
      press(KEY_ENTER, 1);
      wait_end(1);

      // Held key gives one attack; a key during the enemy wait is dropped
      start(3'd0, '0);
      bus.keycode = KEY_ENTER;
      repeat (20) tick();
      bus.keycode = 8'h00;
      tick();
      wait_turn();
      chk("held_ehp", int'(bus.enemy_hp), 20);
      chk("held_my_hp", int'(bus.my_hp), 29);
      press(KEY_ENTER, 1);
      tick();
      press(KEY_ENTER, 1);
      wait_turn();
      chk("wait_key_ehp", int'(bus.enemy_hp), 16);
      chk("wait_key_my_hp", int'(bus.my_hp), 26);
      abort_chk(16, 26);

      // Switch rotates slots and hands the turn to the enemy
      start(3'd0, '0);
      bus.keycode = KEY_S;
      tick();
      chk("sw1_cur", int'(bus.my_cur), 1);
      chk("sw1_turn", int'(bus.player_turn), 0);
      bus.keycode = 8'h00;
      tick();
      wait_turn();
      chk("sw1_my_hp", int'(bus.my_hp), 29);
      chk("sw1_ehp", int'(bus.enemy_hp), 24);
      bus.keycode = KEY_S;
      tick();
      chk("sw2_cur", int'(bus.my_cur), 2);
      chk("sw2_my_hp", int'(bus.my_hp), 32);
      bus.keycode = 8'h00;
      tick();
      wait_turn();
      bus.keycode = KEY_S;
      tick();
      chk("sw3_cur", int'(bus.my_cur), 0);
      chk("sw3_my_hp", int'(bus.my_hp), 32);
      bus.keycode = 8'h00;
      tick();
      wait_turn();
      abort_chk(24, 29);

      // Loss: enemy power 10 faints each slot in four hits
      start(3'd7, '0);
      for (int h = 1; h <= 11; h++) begin
         press(KEY_ENTER, 1);
         wait_turn();
         chk("loss_cur", int'(bus.my_cur), h / 4);
         chk("loss_my_hp", int'(bus.my_hp), 32 - 10 * (h % 4));
         chk("loss_ehp", int'(bus.enemy_hp), 52 - 4 * h);
      end
      bus.keycode = KEY_S;
      tick();
      chk("lone_sw_turn", int'(bus.player_turn), 1);
      chk("lone_sw_cur", int'(bus.my_cur), 2);
      bus.keycode = 8'h00;
      tick();
      chk("lone_sw_turn2", int'(bus.player_turn), 1);
      press(KEY_ENTER, 1);
      wait_end(0);

      // Reset mid-battle
      start(3'd2, '0);
      press(KEY_ENTER, 1);
      rst           = 1'b1;
      bus.is_battle = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst_ehp", int'(bus.enemy_hp), 0);
      chk("midrst_turn", int'(bus.player_turn), 0);
      chk("midrst_result", int'(bus.result), 0);
      tick();

      for (int b = 0; b < 25; b++) rand_battle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/battle_engine.md
# battle_engine

Turn-based battle controller that runs one battle whenever `game_state` is in its Battle state. It holds per-slot HP for the player team and HP for the current enemy, and alternates player and enemy turns. It feeds `game_state` its `my_cur`, `enemy_cur_id`, `end_battle` and `result` inputs. It sits directly upstream of `game_state` and consumes that block's `is_battle`, `my_team` and `cur_battle` outputs.

## Interface
Parameters:
- FULL_HP, 6'd32: player per-slot HP loaded at battle start.
- ENEMY_DELAY, 25'd25000000: cycles the enemy waits before attacking (0.5 s at 50 MHz). Must be ≥1.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high.
- keycode  in  8  raw USB keycode (0 = no key).
- is_battle  in  1  high while `game_state` is in Battle.
- my_team  in  [2:0][2:0]  species id per slot 0..2.
- cur_battle  in  3  battle index 0..7.
- my_cur  out  2  active player slot, 0..2 (never 3).
- enemy_cur_id  out  3  enemy species id.
- end_battle  out  1  one-cycle pulse when the battle finishes.
- result  out  1  1 = player won; valid while end_battle is high, held afterwards.
- my_hp  out  6  HP of slot `my_cur`.
- enemy_hp  out  6  enemy HP.
- player_turn  out  1  high in PlayerTurn.

## Operation
- Key event: `prev_key` is a registered copy of keycode, reset to 0. `key_evt` = (keycode != 0) && (keycode != prev_key). A held key yields exactly one event.
- Keys:
  - ENTER (8'h28) = attack.
  - S (8'h16) = switch.
  - All other keys are ignored.
- Player attack power = 4 + my_team[my_cur], range 4..11.
- Enemy attack power = 3 + cur_battle, range 3..10.
- Enemy id = cur_battle + 3'd4, modulo 8. Enemy HP at load = 24 + 4·cur_battle, range 24..52.
- All HP subtraction saturates at 0. No wrap-around.
- Next-alive search order from slot c: (c+1)%3, then (c+2)%3. A slot is alive if its HP > 0.
- States and transitions:
  - Idle: if is_battle = 1, go to Load.
  - Load (one cycle): all three slot HPs ← FULL_HP, my_cur ← 0, enemy_hp and enemy_cur_id loaded. Go to PlayerTurn.
  - PlayerTurn:
    - ENTER event: enemy_hp ← sat(enemy_hp − atk), go to PlayerResolve.
    - S event with an alive other slot: my_cur ← first alive slot, counter cleared, go to EnemyWait. The switch consumes the turn.
    - S event with no alive other slot: ignored, stay in PlayerTurn.
  - PlayerResolve: if enemy_hp = 0, result ← 1 and go to Done. Otherwise clear the counter and go to EnemyWait.
  - EnemyWait: counter increments each cycle. When it reaches ENEMY_DELAY−1, go to EnemyAttack.
  - EnemyAttack: hp[my_cur] ← sat(hp[my_cur] − enemy atk). Go to EnemyResolve.
  - EnemyResolve:
    - hp[my_cur] > 0: go to PlayerTurn.
    - Else, if an alive slot exists: my_cur ← that slot, go to PlayerTurn.
    - Else: result ← 0, go to Done.
  - Done (one cycle): end_battle = 1. Go to Finish.
  - Finish: go to Idle once is_battle = 0.
- Abort: if is_battle drops in any state from Load through EnemyResolve, go to Idle next cycle. No end_battle pulse is produced; result and HPs are unchanged.
- Reset mid-battle overrides everything and returns the block to Idle with reset values.

## Timing
- Reset values:
  - State = Idle.
  - my_cur = 0, enemy_cur_id = 0.
  - end_battle = 0, result = 0.
  - All HPs = 0, so my_hp = 0 and enemy_hp = 0.
  - player_turn = 0, counter = 0, prev_key = 0.
- is_battle rising at edge k: Load during cycle k+1, PlayerTurn from k+2. player_turn is high from k+2.
- A key event sampled in cycle N shows its HP change at the outputs in N+1.
- Enemy turn: EnemyWait lasts exactly ENEMY_DELAY cycles, then the HP drop is visible one cycle later.
- end_battle is a registered Moore output, high for exactly 1 cycle. `game_state` samples it in Battle and leaves Battle the following cycle. Finish absorbs that exit.
- All outputs are registered or derived from state only. There is no combinational path from keycode to any output.
- Key events outside PlayerTurn are discarded. They are not queued.

## Test plan
- Reset: hold Reset 2 cycles → all outputs 0, state Idle. Assert is_battle with cur_battle = 0 → enemy_hp = 24 and enemy_cur_id = 4 two cycles later; my_hp = 32 and player_turn = 1.
- Win, with ENEMY_DELAY = 4, team {7,1,2}, cur_battle = 0: ENTER, release, ENTER, release, ENTER → enemy_hp goes 13, 2, 0; end_battle pulses 1 cycle with result = 1. Between the attacks my_hp goes 32→29→26.
- Held key: keycode = ENTER held for 20 cycles → exactly one attack. A second ENTER event during EnemyWait has no effect.
- Faint and loss, with FULL_HP = 3 and cur_battle = 0: slot 0 is attacked to 0 → my_cur = 1. Repeat → my_cur = 2. Third faint → end_battle pulse with result = 0.
- Switch: S in PlayerTurn → my_cur = 1 and EnemyWait is entered. Then hp[1] drops, hp[0] is still 32. S pressed with the other two slots at 0 HP → no state change.
- Abort and re-entry: drop is_battle during EnemyWait → Idle, no end_battle. Re-assert with cur_battle = 7 → enemy_hp = 52, enemy_cur_id = 3.
